// File: rtl/rom_prefetch_reader.sv
// rom_prefetch_reader
//   Sequential instruction-fetch reader in front of a synchronous ROM with a
//   1-cycle read latency. It issues word addresses, captures the returned words
//   together with their fetch addresses in a small FIFO, and presents them to the
//   consumer through a valid/ready handshake. A redirect flushes everything and
//   restarts fetching at a new address.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   redirect_valid/addr    1-cycle flush + restart request
//   mem_addr, mem_rd_en    ROM address and "real fetch" qualifier
//   mem_data               ROM word, valid the cycle after the issuing cycle
//   out_valid/ready        consumer handshake on the FIFO head
//   out_data, out_addr     head word and the address it was fetched from
//   fifo_level             number of entries held
module rom_prefetch_reader #(
    parameter int          ADDR_W     = 10,
    parameter int          DATA_W     = 16,
    parameter int          DEPTH      = 4,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_addr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd_en,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [$clog2(DEPTH):0]       fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] pend_addr;
    logic              pending;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [LVL_W:0]    committed;
    logic              wr_en;
    logic              pop;

    // Entries held plus the word still in flight from the ROM. A pop in the
    // same cycle is deliberately not credited, so the FIFO can never overflow.
    assign committed  = {1'b0, level} + {{LVL_W{1'b0}}, pending};
    assign mem_rd_en  = reset_n && !redirect_valid && (committed < (LVL_W+1)'(DEPTH));
    assign mem_addr   = fetch_addr;

    // A redirect squashes the word returning this cycle.
    assign wr_en      = pending && !redirect_valid;
    assign pop        = out_valid && out_ready && !redirect_valid;

    assign out_valid  = (level != '0);
    assign out_data   = data_mem[rd_ptr];
    assign out_addr   = addr_mem[rd_ptr];
    assign fifo_level = level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_addr <= ADDR_W'(RESET_ADDR);
            pend_addr  <= ADDR_W'(RESET_ADDR);
            pending    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else if (redirect_valid) begin
            fetch_addr <= redirect_addr;
            pending    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else begin
            if (mem_rd_en) begin
                fetch_addr <= fetch_addr + ADDR_W'(1);
                pend_addr  <= fetch_addr;
                pending    <= 1'b1;
            end else begin
                pending    <= 1'b0;
            end
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(wr_en) - LVL_W'(pop);
        end
    end

    // Storage needs no reset: the level gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr] <= mem_data;
            addr_mem[wr_ptr] <= pend_addr;
        end
    end

endmodule

// File: tb/tb_rom_prefetch_reader.sv
// Testbench for rom_prefetch_reader: a ROM model drives mem_data and the bench
// tracks the expected output stream as "next address the consumer must see",
// advancing it on every handshake and reloading it on redirect / reset.
module tb_rom_prefetch_reader;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic [2:0]    fifo_level;

    int checks = 0;
    int errors = 0;

    logic          rom_nop = 1'b0;
    logic [AW-1:0] exp_next;

    // values sampled by tick() just before the clock edge
    logic          hs;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_data;
    logic          rd_en_s;

    rom_prefetch_reader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_ADDR(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic nop, input logic [AW-1:0] a);
        return nop ? 16'h4E71 : ({6'b0, a} ^ 16'h4E71);
    endfunction

    // synchronous ROM: registers the address every edge
    always @(posedge clk) mem_data <= rom_fn(rom_nop, mem_addr);

    // Drive inputs for one cycle (called just after a negedge), sample, advance.
    task automatic tick(input logic rdy, input logic rv, input logic [AW-1:0] ra);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_addr  = ra;
        #1;
        hs      = out_valid && out_ready;
        hs_addr = out_addr;
        hs_data = out_data;
        rd_en_s = mem_rd_en;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || mem_rd_en !== 1'b0 || mem_addr !== 10'h000) begin
            errors++;
            $display("FAIL reset_state: valid=%b level=%0d rd_en=%b addr=%h required 0 0 0 000",
                     out_valid, fifo_level, mem_rd_en, mem_addr);
        end
        @(negedge clk);
        reset_n  = 1'b1;
        exp_next = 10'h000;
        tick(1'b1, 1'b0, '0);
        checks++;
        if (rd_en_s !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_issue: rd_en=%b valid=%b required 1 0", rd_en_s, out_valid);
        end
        tick(1'b1, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b1 || fifo_level !== 3'd1 || out_addr !== 10'h000) begin
            errors++;
            $display("FAIL reset_latency: valid=%b level=%0d addr=%h required 1 1 000",
                     out_valid, fifo_level, out_addr);
        end
    endtask

    // 1: one word per cycle, no gaps, addresses 0,1,2...
    task automatic test_stream();
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b0, '0);
            checks++;
            if (!hs || hs_addr !== exp_next || hs_data !== rom_fn(rom_nop, exp_next)) begin
                errors++;
                $display("FAIL stream[%0d]: hs=%b addr=%h data=%h required addr=%h data=%h",
                         i, hs, hs_addr, hs_data, exp_next, rom_fn(rom_nop, exp_next));
            end
            exp_next++;
        end
    endtask

    // 2: back-pressure fills the FIFO, then contiguous drain
    task automatic test_backpressure();
        int pops;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, '0);
        #1;
        checks++;
        if (fifo_level !== 3'd4 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL full_state: level=%0d rd_en=%b required 4 0", fifo_level, mem_rd_en);
        end
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, '0);
            if (hs) begin
                pops++;
                checks++;
                if (hs_addr !== exp_next || hs_data !== rom_fn(rom_nop, exp_next)) begin
                    errors++;
                    $display("FAIL drain: addr=%h data=%h required %h %h",
                             hs_addr, hs_data, exp_next, rom_fn(rom_nop, exp_next));
                end
                exp_next++;
            end
        end
        checks++;
        if (pops !== 20) begin
            errors++;
            $display("FAIL drain_rate: pops=%0d required 20", pops);
        end
    endtask

    // 3: redirect while full, across the address wrap
    task automatic test_redirect_full();
        int pops;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 10'h3FE);
        exp_next = 10'h3FE;
        checks++;
        if (rd_en_s !== 1'b0 || fifo_level !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: rd_en=%b level=%0d valid=%b required 0 0 0",
                     rd_en_s, fifo_level, out_valid);
        end
        pops = 0;
        for (int i = 0; i < 20 && pops < 4; i++) begin
            tick(1'b1, 1'b0, '0);
            if (hs) begin
                pops++;
                checks++;
                if (hs_addr !== exp_next || hs_data !== rom_fn(rom_nop, exp_next)) begin
                    errors++;
                    $display("FAIL redirect_wrap: addr=%h data=%h required %h %h",
                             hs_addr, hs_data, exp_next, rom_fn(rom_nop, exp_next));
                end
                exp_next++;
            end
        end
        checks++;
        if (pops !== 4 || exp_next !== 10'h002) begin
            errors++;
            $display("FAIL redirect_timeout: pops=%0d next=%h required 4 002", pops, exp_next);
        end
    endtask

    // 4: back-to-back redirects, the later wins
    task automatic test_double_redirect();
        int pops;
        tick(1'b1, 1'b1, 10'h100);
        tick(1'b1, 1'b1, 10'h200);
        exp_next = 10'h200;
        checks++;
        if (hs !== 1'b0) begin
            errors++;
            $display("FAIL double_redirect_flush: hs=%b required 0", hs);
        end
        pops = 0;
        for (int i = 0; i < 20 && pops < 8; i++) begin
            tick(1'b1, 1'b0, '0);
            if (hs) begin
                pops++;
                checks++;
                if (hs_addr !== exp_next || hs_data !== rom_fn(rom_nop, exp_next)) begin
                    errors++;
                    $display("FAIL double_redirect: addr=%h data=%h required %h %h",
                             hs_addr, hs_data, exp_next, rom_fn(rom_nop, exp_next));
                end
                exp_next++;
            end
        end
        checks++;
        if (pops !== 8) begin
            errors++;
            $display("FAIL double_redirect_timeout: pops=%0d required 8", pops);
        end
    endtask

    // 5: reset asserted mid-stream with a word in flight
    task automatic test_reset_mid();
        int pops;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, '0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || mem_rd_en !== 1'b0 || mem_addr !== 10'h000) begin
            errors++;
            $display("FAIL reset_mid: valid=%b level=%0d rd_en=%b addr=%h required 0 0 0 000",
                     out_valid, fifo_level, mem_rd_en, mem_addr);
        end
        @(negedge clk);
        tick(1'b1, 1'b0, '0);
        reset_n  = 1'b1;
        exp_next = 10'h000;
        pops = 0;
        for (int i = 0; i < 20 && pops < 6; i++) begin
            tick(1'b1, 1'b0, '0);
            if (hs) begin
                pops++;
                checks++;
                if (hs_addr !== exp_next || hs_data !== rom_fn(rom_nop, exp_next)) begin
                    errors++;
                    $display("FAIL reset_restart: addr=%h data=%h required %h %h",
                             hs_addr, hs_data, exp_next, rom_fn(rom_nop, exp_next));
                end
                exp_next++;
            end
        end
        checks++;
        if (pops !== 6) begin
            errors++;
            $display("FAIL reset_restart_timeout: pops=%0d required 6", pops);
        end
    endtask

    // 6: random ready and redirects, both ROM images
    task automatic test_random();
        int pops;
        logic rdy, rv;
        logic [AW-1:0] ra;
        pops = 0;
        for (int phase = 0; phase < 2; phase++) begin
            rom_nop = (phase == 1);
            ra = AW'($urandom);
            tick(1'b0, 1'b1, ra);
            exp_next = ra;
            for (int i = 0; i < 5000; i++) begin
                rdy = ($urandom_range(0, 3) != 0);
                rv  = ($urandom_range(0, 63) == 0);
                ra  = AW'($urandom);
                tick(rdy, rv, ra);
                if (hs) begin
                    pops++;
                    checks++;
                    if (hs_addr !== exp_next || hs_data !== rom_fn(rom_nop, exp_next)) begin
                        errors++;
                        $display("FAIL random: addr=%h data=%h required %h %h",
                                 hs_addr, hs_data, exp_next, rom_fn(rom_nop, exp_next));
                    end
                    exp_next++;
                end
                if (rv) exp_next = ra;
                checks++;
                if (fifo_level > 3'd4 || out_valid !== (fifo_level != 3'd0)) begin
                    errors++;
                    $display("FAIL random_level: level=%0d valid=%b required level<=4 and valid==(level!=0)",
                             fifo_level, out_valid);
                end
            end
        end
        checks++;
        if (pops < 4000) begin
            errors++;
            $display("FAIL random_progress: pops=%0d required >= 4000", pops);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_double_redirect();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
